// File: rtl/divn_chunked.sv
// divn_chunked: sequential restoring divider with chunked valid/ready transfer.
// Operands arrive low word first (dividend, then divisor). The quotient and
// remainder leave low word first (quotient words, then remainder words).
// Signed mode divides magnitudes and fixes the signs afterwards, so results
// truncate toward zero and the remainder follows the sign of the dividend.
module divn_chunked #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int NW = WIDTH / CHUNK;
  localparam int CW = $clog2(NW + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, PREP, CALC, FIX, OUT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;        // word index within the current transfer phase
  logic [BW-1:0]    calc_cnt;   // quotient bit index during CALC
  logic             out_rem;    // 0: sending quotient words, 1: remainder words
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] n_reg, d_reg, r_reg, q_reg;
  logic             smode, sign_q, sign_r, zero_div;

  logic             in_fire, out_fire, last_word, last_bit;
  logic             sa, sb;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub;
  logic             r_ge;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (cnt == CW'(NW - 1));
  assign last_bit  = (calc_cnt == BW'(WIDTH - 1));

  assign sa = smode && a_reg[WIDTH-1];
  assign sb = smode && b_reg[WIDTH-1];

  // The shifted partial remainder keeps its carry bit so divisors above
  // 2^(WIDTH-1) still compare correctly; the difference always fits WIDTH bits.
  assign r_sh  = {r_reg, n_reg[WIDTH-1]};
  assign r_ge  = (r_sh >= {1'b0, d_reg});
  assign r_sub = r_sh[WIDTH-1:0] - d_reg;

  // Next-state decode and handshake/status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    div_by_zero = 1'b0;
    busy        = (state != LOAD_A) || (cnt != '0);
    unique case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_next = PREP;
      end
      PREP: state_next = (b_reg == '0) ? OUT : CALC;
      CALC: if (last_bit) state_next = FIX;
      FIX:  state_next = OUT;
      OUT: begin
        out_valid   = 1'b1;
        div_by_zero = zero_div;
        out_data    = out_rem ? r_reg[CHUNK*int'(cnt) +: CHUNK]
                              : q_reg[CHUNK*int'(cnt) +: CHUNK];
        if (out_ready && out_rem && last_word) state_next = LOAD_A;
      end
      default: state_next = LOAD_A;
    endcase
    // Outputs are held inactive while reset is asserted.
    if (!reset) begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      div_by_zero = 1'b0;
      busy        = 1'b0;
    end
  end

  // State register, operand capture, division datapath and output sequencing.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are cleared together with the control
    // state so an aborted operation leaves no stale operand or result behind.
    if (!reset) begin
      state    <= LOAD_A;
      cnt      <= '0;
      calc_cnt <= '0;
      out_rem  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      smode    <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from
      // the values present before this edge, independent of statement order.
      state <= state_next;
      unique case (state)
        LOAD_A: if (in_fire) begin
          a_reg[CHUNK*int'(cnt) +: CHUNK] <= in_data;
          if (cnt == '0) smode <= signed_mode;
          cnt <= last_word ? '0 : cnt + CW'(1);
        end
        LOAD_B: if (in_fire) begin
          b_reg[CHUNK*int'(cnt) +: CHUNK] <= in_data;
          cnt <= last_word ? '0 : cnt + CW'(1);
        end
        PREP: begin
          zero_div <= (b_reg == '0);
          calc_cnt <= '0;
          out_rem  <= 1'b0;
          if (b_reg == '0) begin
            q_reg <= '1;
            r_reg <= a_reg;
          end else begin
            n_reg  <= sa ? -a_reg : a_reg;
            d_reg  <= sb ? -b_reg : b_reg;
            r_reg  <= '0;
            q_reg  <= '0;
            sign_q <= sa ^ sb;
            sign_r <= sa;
          end
        end
        CALC: begin
          n_reg    <= {n_reg[WIDTH-2:0], 1'b0};
          r_reg    <= r_ge ? r_sub : r_sh[WIDTH-1:0];
          q_reg    <= {q_reg[WIDTH-2:0], r_ge};
          calc_cnt <= calc_cnt + BW'(1);
        end
        FIX: begin
          if (sign_q) q_reg <= -q_reg;
          if (sign_r) r_reg <= -r_reg;
        end
        OUT: if (out_fire) begin
          if (last_word) begin
            cnt     <= '0;
            out_rem <= ~out_rem;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divn_chunked.md
# divn_chunked

Parametrised sequential integer divider for the MicroBlaze-attached accelerator path. It is the successor to the fixed 64-bit chunked divider. Operands arrive as CHUNK-bit words over a valid/ready port, and the block computes a WIDTH-bit quotient and remainder one bit per cycle, in unsigned or signed mode. Results return over a second valid/ready port, and divide-by-zero is flagged explicitly.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 32, transfer word width; 8 ≤ CHUNK ≤ WIDTH.
- NW (localparam), WIDTH/CHUNK, words per operand.
---
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- signed_mode  in  1  sampled with the first dividend word; 1 = two's-complement division.
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  CHUNK  operand word.
- out_valid  out  1  out_data holds a valid result word.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  CHUNK  result word.
- busy  out  1  high whenever state ≠ LOAD_A or a LOAD_A transfer is partly done.
- div_by_zero  out  1  divisor was 0 for the current result; valid while in OUT.

## Operation
- Transfer: a word moves on a rising edge with valid && ready. Word order is low chunk first.
- States:
  - LOAD_A: accept NW dividend words. in_ready = 1.
  - LOAD_B: accept NW divisor words. in_ready = 1.
  - PREP: 1 cycle. Latch the zero-divisor check. In signed mode, take the absolute values of both operands and record sign_q = sa^sb and sign_r = sa.
  - CALC: WIDTH cycles of restoring division. Each cycle: r' = {r[WIDTH-2:0], n[msb]} and shift n left. If r' ≥ d, then r = r' − d and q bit = 1; otherwise r = r' and q bit = 0.
  - FIX: 1 cycle. Negate q if sign_q. Negate r if sign_r.
  - OUT: present NW quotient words (low first), then NW remainder words. After the last accepted word, return to LOAD_A.
- Word counter: log2(NW+1) bits. Clears on every state change.
- Divide by zero (divisor == 0): PREP goes directly to OUT. Quotient = all ones. Remainder = dividend as loaded, raw bits with no sign processing. div_by_zero = 1.
- Signed semantics: truncation toward zero; remainder takes the sign of the dividend. MIN / −1 yields quotient = MIN and remainder = 0, the natural wrap. No flag is raised for this case.
- Absolute value and negation are WIDTH-bit two's complement; |MIN| = MIN treated as unsigned 2^(WIDTH−1).
- in_valid is ignored outside the LOAD states. out_valid is low outside OUT.

## Timing
- Reset values: in_ready = 0 during reset, then 1 in LOAD_A on the first cycle after release. out_valid = 0, out_data = 0, busy = 0, div_by_zero = 0. All datapath registers are cleared and state = LOAD_A.
- Reset asserted in any state, including mid-CALC or mid-OUT, aborts the operation on that edge. Partial operands and results are discarded.
- Latency:
  - Normal divisor: PREP occupies the cycle after the edge that accepts the last divisor word. out_valid rises WIDTH+2 edges after that accepting edge (PREP + WIDTH CALC + FIX).
  - Zero divisor: out_valid rises 1 edge after PREP.
- Throughput: one word per cycle in LOAD and OUT when the handshake is unstalled. Minimum operation time is 2·NW + WIDTH + 2 + 2·NW cycles.
- Backpressure: out_data and out_valid stay stable while out_ready = 0. out_ready is ignored when out_valid = 0.
- The block does not accept new operands until the final remainder word has been accepted. There is no overlap between operations.
- signed_mode changes after the first dividend word have no effect on the operation in progress.

## Test plan
- Unsigned, WIDTH=64/CHUNK=32: 100 / 7 → quotient words 14, 0; remainder words 2, 0; div_by_zero = 0. out_valid rises exactly 66 cycles after the last divisor word is accepted.
- Signed: −100 / 7 → quotient 0xFFFFFFFF_FFFFFFF2, remainder 0xFFFFFFFF_FFFFFFFE. Signed 100 / −7 → quotient −14, remainder +2.
- Divide by zero: 0x12345678_9ABCDEF0 / 0 → quotient all ones, remainder = dividend, div_by_zero = 1, and no WIDTH-cycle CALC phase.
- Signed MIN / −1: 0x80000000_00000000 / 0xFFFFFFFF_FFFFFFFF → quotient 0x80000000_00000000, remainder 0.
- Backpressure and gaps: in_valid toggles 1-0-1 during loading; out_ready is held low for 5 cycles on the second result word. Results must be unchanged, each word is delivered exactly once, and out_data stays stable while stalled.
- Reset mid-CALC: assert reset for 1 cycle during the 20th CALC cycle. After release: state = LOAD_A, out_valid = 0, busy = 0. A fresh 1000 / 10 then gives quotient 100 and remainder 0. Repeat the 100 / 7 case with WIDTH=32/CHUNK=8 (NW = 4).
